// File: rtl/pla_cube_eval.sv
//-----------------------------------------------------------------------------
// pla_cube_eval
//
// Programmable sum-of-products evaluator. A run-time loaded table of cubes
// (care mask, literal polarity, output mask) is evaluated against each
// accepted input vector, one cube per clock, and the OR of the output masks
// of all matching cubes is returned over a valid/ready handshake.
//
// Optional feature (compile-time macro):
//   PLA_EARLY_EXIT_EN - leave EVAL as soon as the accumulator is all-ones.
//                       When undefined, latency is always len+1 cycles.
//
// Parameters:
//   N_IN     number of primary inputs (1..64)
//   N_OUT    number of outputs (1..32)
//   N_CUBES  cube table depth, power of two (2..256)
//   AW       cube address width, derived from N_CUBES
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   cfg_we       write cube cfg_addr with cfg_care / cfg_val / cfg_omask
//   cfg_len_we   write the active cube count cfg_len (0..N_CUBES)
//   cfg_err      one-cycle pulse after a rejected configuration write
//   in_valid/in_ready/x    input vector handshake
//   out_valid/out_ready/y  result handshake
//-----------------------------------------------------------------------------
module pla_cube_eval #(
    parameter  int N_IN    = 16,
    parameter  int N_OUT   = 1,
    parameter  int N_CUBES = 32,
    localparam int AW      = $clog2(N_CUBES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [N_IN-1:0]   cfg_care,
    input  logic [N_IN-1:0]   cfg_val,
    input  logic [N_OUT-1:0]  cfg_omask,
    input  logic              cfg_len_we,
    input  logic [AW:0]       cfg_len,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  y
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [AW:0]    LEN_MAX  = (AW + 1)'(N_CUBES);
    localparam logic [AW:0]    LEN_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]    LEN_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW-1:0]  IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]  IDX_ONE  = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [N_OUT-1:0] ACC_ZERO = {N_OUT{1'b0}};

    // A cube matches when every cared-for input bit equals its literal value.
    function automatic logic cube_hit(
        input logic [N_IN-1:0] xv,
        input logic [N_IN-1:0] val,
        input logic [N_IN-1:0] care
    );
        cube_hit = (((xv ^ val) & care) == {N_IN{1'b0}});
    endfunction

    // Cube table (deliberately not reset: only len is cleared).
    logic [N_IN-1:0]  care_mem_q  [N_CUBES];
    logic [N_IN-1:0]  val_mem_q   [N_CUBES];
    logic [N_OUT-1:0] omask_mem_q [N_CUBES];

    logic [1:0]       state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [N_IN-1:0]  x_q, x_d;
    logic [N_OUT-1:0] acc_q, acc_d;
    logic             cfg_err_q, cfg_err_d;
    logic             out_valid_q, out_valid_d;

    logic             tbl_we_s;
    logic             len_ok_s;
    logic             last_s;
    logic             early_s;
    logic [N_OUT-1:0] hit_mask_s;
    logic [N_OUT-1:0] acc_next_s;

    // Contribution of the cube currently addressed by idx.
    always_comb begin
        if (cube_hit(x_q, val_mem_q[idx_q], care_mem_q[idx_q])) begin
            hit_mask_s = omask_mem_q[idx_q];
        end else begin
            hit_mask_s = ACC_ZERO;
        end
        acc_next_s = acc_q | hit_mask_s;
        last_s     = (({1'b0, idx_q} + LEN_ONE) == len_q);
        len_ok_s   = (cfg_len <= LEN_MAX);
`ifdef PLA_EARLY_EXIT_EN
        // Once every output is set, later cubes cannot change the result.
        early_s    = &acc_next_s;
`else
        early_s    = 1'b0;
`endif
    end

    // Configuration acceptance and the IDLE/EVAL/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        x_d         = x_q;
        acc_d       = acc_q;
        tbl_we_s    = 1'b0;
        cfg_err_d   = 1'b0;
        out_valid_d = 1'b0;

        // Config writes only land in IDLE; len is applied before the
        // handshake decision so a same-cycle vector sees the new value.
        if (state_q == ST_IDLE) begin
            tbl_we_s = cfg_we;
            if (cfg_len_we && len_ok_s) begin
                len_d = cfg_len;
            end else begin
                len_d = len_q;
            end
            cfg_err_d = cfg_len_we & ~len_ok_s;
        end else begin
            tbl_we_s  = 1'b0;
            cfg_err_d = cfg_we | cfg_len_we;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d   = x;
                    acc_d = ACC_ZERO;
                    idx_d = IDX_ZERO;
                    if (len_d != LEN_ZERO) begin
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                acc_d = acc_next_s;
                idx_d = idx_q + IDX_ONE;
                if (last_s || early_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_DONE);
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= LEN_ZERO;
            idx_q       <= IDX_ZERO;
            x_q         <= {N_IN{1'b0}};
            acc_q       <= ACC_ZERO;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            cfg_err_q   <= cfg_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Cube table write port.
    always_ff @(posedge clk) begin
        if (tbl_we_s) begin
            care_mem_q[cfg_addr]  <= cfg_care;
            val_mem_q[cfg_addr]   <= cfg_val;
            omask_mem_q[cfg_addr] <= cfg_omask;
        end
    end

    // in_ready is forced low while reset is held.
    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign y         = acc_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pla_cube_eval.sv
//-----------------------------------------------------------------------------
// tb_pla_cube_eval
//
// Drives pla_cube_eval (N_IN=16, N_OUT=2, N_CUBES=32) with directed and
// randomized traffic. A behavioural model (plain loop over the cube list)
// predicts result and latency for every accepted vector; one compare
// process checks handshake outputs, y and cfg_err every cycle.
// Honours PLA_EARLY_EXIT_EN in the same way as the design.
//-----------------------------------------------------------------------------
module tb_pla_cube_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_care;
    logic [15:0] cfg_val;
    logic [1:0]  cfg_omask;
    logic        cfg_len_we;
    logic [5:0]  cfg_len;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  y;

    pla_cube_eval #(.N_IN(16), .N_OUT(2), .N_CUBES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_care   (cfg_care),
        .cfg_val    (cfg_val),
        .cfg_omask  (cfg_omask),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y)
    );

    always #5 clk = ~clk;

    // Edge counter: edge n sets cyc to n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [1:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   err_edge = -1;
    int   n_pass   = 0;
    int   n_total  = 0;
    bit   rand_rdy = 1'b0;

    // Model state.
    logic [15:0] mcare [32];
    logic [15:0] mval  [32];
    logic [1:0]  mom   [32];
    int          mlen  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    endtask

    // Sum-of-products over the active cubes; k = edges from handshake to DONE.
    function automatic void model(input logic [15:0] xv, output logic [1:0] yo, output int ko);
        yo = 2'b00;
        ko = mlen;
        for (int i = 0; i < mlen; i++) begin
            if (((xv ^ mval[i]) & mcare[i]) == 16'h0000) yo = yo | mom[i];
`ifdef PLA_EARLY_EXIT_EN
            if (yo == 2'b11) begin
                ko = i + 1;
                break;
            end
`endif
        end
    endfunction

    // Per-cycle compare against the expectation queue.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        end else begin
            chk("cfg_err", {63'd0, cfg_err}, {63'd0, (cyc == err_edge)});
            if (exp_q.size() != 0) begin
                logic ev;
                ev = (cyc >= exp_q[0].due);
                chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
                chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
                if (ev) begin
                    chk("y", {62'd0, y}, {62'd0, exp_q[0].y});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
                chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
            end
        end
    end

    task automatic wait_done();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(posedge clk); #2;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        out_ready = 1'b1;
    endtask

    // Config-only cycle; dropped with cfg_err when the engine is busy.
    task automatic cfg(input bit wc, input int a, input logic [15:0] c, input logic [15:0] v,
                       input logic [1:0] o, input bit wl, input int l);
        bit busy, bad;
        busy = (exp_q.size() != 0);
        bad  = busy ? (wc | wl) : (wl && l > 32);
        cfg_we = wc; cfg_addr = a[4:0]; cfg_care = c; cfg_val = v; cfg_omask = o;
        cfg_len_we = wl; cfg_len = l[5:0];
        if (!busy) begin
            if (wc) begin mcare[a] = c; mval[a] = v; mom[a] = o; end
            if (wl && l <= 32) mlen = l;
        end
        @(posedge clk);
        if (bad) err_edge = cyc + 1;
        #2;
        cfg_we = 1'b0; cfg_len_we = 1'b0;
    endtask

    // Offer one vector, optionally with same-cycle config writes.
    task automatic send(input logic [15:0] xv, input bit wc, input int a, input logic [15:0] c,
                        input logic [15:0] v, input logic [1:0] o, input bit wl, input int l,
                        input bit nowait);
        logic [1:0] ye;
        int ke;
        bit bad;
        for (int n = 0; n < 300 && !in_ready; n++) begin
            @(posedge clk); #2;
        end
        if (!in_ready) begin
            chk("ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1; x = xv;
        cfg_we = wc; cfg_addr = a[4:0]; cfg_care = c; cfg_val = v; cfg_omask = o;
        cfg_len_we = wl; cfg_len = l[5:0];
        if (wc) begin mcare[a] = c; mval[a] = v; mom[a] = o; end
        bad = wl && l > 32;
        if (wl && !bad) mlen = l;
        model(xv, ye, ke);
        @(posedge clk);
        exp_q.push_back('{due: cyc + 1 + ke, y: ye});
        if (bad) err_edge = cyc + 1;
        #2;
        in_valid = 1'b0; x = 16'($urandom);
        cfg_we = 1'b0; cfg_len_we = 1'b0;
        if (!nowait) wait_done();
    endtask

    task automatic pin(input string nm, input logic [15:0] xv, input logic [1:0] ye, input int ke);
        logic [1:0] ym;
        int km;
        model(xv, ym, km);
        chk({nm, "_y"}, {62'd0, ym}, {62'd0, ye});
        chk({nm, "_lat"}, 64'(km), 64'(ke));
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_care = 16'h0; cfg_val = 16'h0;
        cfg_omask = 2'b00; cfg_len_we = 1'b0; cfg_len = 6'd0; in_valid = 1'b0;
        x = 16'h0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin mcare[i] = 16'h0; mval[i] = 16'h0; mom[i] = 2'b00; end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // Fresh engine: len=0 gives y=0 one cycle after the handshake.
        pin("len0", 16'hFFFF, 2'b00, 0);
        send(16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single cube on the low byte.
        cfg(1, 0, 16'h00FF, 16'h00A5, 2'b01, 1, 1);
        pin("a5_hit", 16'h12A5, 2'b01, 1);
        send(16'h12A5, 0, 0, 0, 0, 0, 0, 0, 0);
        pin("a5_miss", 16'h12A4, 2'b00, 1);
        send(16'h12A4, 0, 0, 0, 0, 0, 0, 0, 0);

        // Result held in DONE while out_ready is low; in_valid ignored.
        send(16'h12A5, 0, 0, 0, 0, 0, 0, 0, 1);
        out_ready = 1'b0; in_valid = 1'b1; x = 16'h12A4;
        repeat (10) begin @(posedge clk); #2; end
        chk("hold_y", {62'd0, y}, 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        wait_done();

        // Three cubes completing on cube2.
        cfg(1, 0, 16'hFFFF, 16'h0000, 2'b01, 0, 0);
        cfg(1, 1, 16'h0000, 16'h0000, 2'b10, 0, 0);
        cfg(1, 2, 16'hFFFF, 16'h1234, 2'b01, 1, 3);
        pin("three", 16'h1234, 2'b11, 3);
        send(16'h1234, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write during EVAL is dropped; result unchanged afterwards.
        send(16'h1234, 0, 0, 0, 0, 0, 0, 0, 1);
        cfg(1, 1, 16'h0000, 16'h0000, 2'b01, 0, 0);
        wait_done();
        pin("after_drop", 16'h1234, 2'b11, 3);
        send(16'h1234, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reorder: all-ones reached at cube1.
        cfg(1, 0, 16'h0000, 16'h0000, 2'b10, 0, 0);
        cfg(1, 1, 16'hFFFF, 16'h1234, 2'b01, 0, 0);
        cfg(1, 2, 16'hFFFF, 16'h0000, 2'b01, 0, 0);
`ifdef PLA_EARLY_EXIT_EN
        pin("reorder", 16'h1234, 2'b11, 2);
`else
        pin("reorder", 16'h1234, 2'b11, 3);
`endif
        send(16'h1234, 0, 0, 0, 0, 0, 0, 0, 0);

        // Out-of-range len rejected; same-cycle len write applies to the vector.
        cfg(0, 0, 0, 0, 0, 1, 33);
        send(16'h1234, 0, 0, 0, 0, 0, 1, 1, 0);
        pin("len1_now", 16'h5555, 2'b10, 1);

        // Random table and traffic.
        for (int i = 0; i < 32; i++)
            cfg(1, i, 16'($urandom & $urandom & $urandom), 16'($urandom), 2'($urandom), 0, 0);
        rand_rdy = 1'b1;
        for (int t = 0; t < 80; t++) begin
            int l;
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
            case ($urandom_range(0, 5))
                0: cfg(1, $urandom_range(0, 31), 16'($urandom & $urandom), 16'($urandom),
                       2'($urandom), $urandom_range(0, 1), l);
                1: begin
                    send(16'($urandom), 0, 0, 0, 0, 0, 0, 0, 1);
                    cfg($urandom_range(0, 1), $urandom_range(0, 31), 16'h0, 16'h0, 2'b11, 1, l);
                    wait_done();
                end
                default: send(16'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 31),
                              16'($urandom & $urandom & $urandom), 16'($urandom), 2'($urandom),
                              $urandom_range(0, 3) == 0, l, 0);
            endcase
        end
        rand_rdy = 1'b0;

        // Reset in the middle of a 32-cube evaluation.
        cfg(0, 0, 0, 0, 0, 1, 32);
        send(16'($urandom), 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) begin @(posedge clk); #2; end
        rst = 1'b1;
        mlen = 0;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        @(posedge clk); #2;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        pin("post_rst", 16'hFFFF, 2'b00, 0);
        send(16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
